// File: rtl/program_ram_arbiter.sv
// Cartridge program RAM front end: packs detected color nits into words, queues them
// in a 2-deep write FIFO and arbitrates the single RAM port between loader writes and CPU fetches.
module program_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12,
  parameter int NITS   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              color_valid,
  input  logic [1:0]        color,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W:0]   load_count,
  output logic              load_full,
  output logic              overflow
);

  localparam int CNT_W = (NITS > 1) ? $clog2(NITS) : 1;
  localparam logic [CNT_W-1:0] LAST_NIT = CNT_W'(NITS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_READ      = 2'd2;
  localparam logic [1:0] S_READ_DATA = 2'd3;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  logic [1:0]        state;
  logic              last_grant;
  logic [CNT_W-1:0]  nit_cnt;
  logic [DATA_W-1:0] shift_word;
  logic [DATA_W-1:0] next_word;
  logic [ADDR_W-1:0] wr_ptr;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wr;
  logic              fifo_rd;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;

  logic word_done;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;
  logic flush;
  logic want_write;
  logic grant_write;
  logic grant_read;

  // Packing and arbitration decisions for the current cycle
  assign next_word  = {shift_word[DATA_W-3:0], color};
  assign word_done  = color_valid && !load_start && (nit_cnt == LAST_NIT);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_head  = fifo_mem[fifo_rd];
  assign pop        = (state == S_WRITE);
  // A pop in the same cycle frees the slot, so a completed word is never lost then
  assign push       = word_done && !load_full && (!fifo_full || pop);
  assign drop       = word_done && !push;
  // Words still queued once the RAM is full can never be written; discard them
  assign flush      = load_full && !fifo_empty;
  assign want_write = !fifo_empty && !load_full && !load_start;
  assign grant_write = (state == S_IDLE) && want_write &&
                       (!cpu_req || (last_grant == GRANT_READ));
  assign grant_read  = (state == S_IDLE) && cpu_req && !grant_write;

  // Nit assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nit_cnt    <= '0;
      shift_word <= '0;
    end else if (load_start) begin
      nit_cnt    <= '0;
      shift_word <= '0;
    end else if (color_valid) begin
      if (nit_cnt == LAST_NIT) begin
        nit_cnt    <= '0;
        shift_word <= '0;
      end else begin
        nit_cnt    <= nit_cnt + 1'b1;
        shift_word <= next_word;
      end
    end
  end

  // Write FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr     <= 1'b0;
      fifo_rd     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (load_start || flush) begin
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr] <= next_word;
        fifo_wr           <= ~fifo_wr;
      end
      if (pop) begin
        fifo_rd <= ~fifo_rd;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Load progress and sticky status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      load_count <= '0;
      load_full  <= 1'b0;
      overflow   <= 1'b0;
    end else if (load_start) begin
      wr_ptr     <= '0;
      load_count <= '0;
      load_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop) begin
        load_count <= load_count + 1'b1;
        if (wr_ptr == '1) begin
          load_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (drop || flush) begin
        overflow <= 1'b1;
      end
    end
  end

  // Port FSM with registered RAM and CPU outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= GRANT_READ;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      cpu_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      ram_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_write) begin
            state      <= S_WRITE;
            last_grant <= GRANT_WRITE;
            ram_we     <= 1'b1;
            ram_addr   <= wr_ptr;
            ram_din    <= fifo_head;
          end else if (grant_read) begin
            state      <= S_READ;
            last_grant <= GRANT_READ;
            ram_addr   <= cpu_addr;
            cpu_ack    <= 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ: begin
          state <= S_READ_DATA;
        end
        S_READ_DATA: begin
          cpu_rdata  <= ram_dout;
          cpu_rvalid <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/program_ram_arbiter.md
PROGRAM_RAM_ARBITER -- requirements
Module: program_ram_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL provide parameter DATA_W, default 12, RAM word width.
REQ-003 SHALL provide parameter NITS, default 6, 2-bit color nits packed per word (NITS*2 = DATA_W).
REQ-004 SHALL provide port clk  input  1  system clock (1 MHz divided clock); reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port load_start  input  1  single-cycle pulse that begins a new cartridge load.
REQ-006 SHALL provide port color_valid  input  1  single-cycle strobe marking a detected color.
REQ-007 SHALL provide port color  input  2  detected color nit (R=0, G=1, B=2, Y=3).
REQ-008 SHALL provide port cpu_req  input  1  CPU fetch request, held high until accepted.
REQ-009 SHALL provide port cpu_addr  input  ADDR_W  CPU fetch address, stable while cpu_req is high.
REQ-010 SHALL provide port cpu_ack  output  1  one-cycle pulse marking acceptance of cpu_req.
REQ-011 SHALL provide port cpu_rdata  output  DATA_W  registered fetch data.
REQ-012 SHALL provide port cpu_rvalid  output  1  one-cycle pulse marking valid cpu_rdata.
REQ-013 SHALL provide ports ram_addr  output  ADDR_W; ram_din  output  DATA_W; ram_we  output  1; ram_dout  input  DATA_W. Together these form a single-port synchronous RAM with 1-cycle read latency.
REQ-014 SHALL provide port load_count  output  ADDR_W+1  number of words written since the last load_start.
REQ-015 SHALL provide ports load_full  output  1  and overflow  output  1  (sticky status bits).

Function
REQ-016 SHALL pack nits MSB-first: the first nit of a word lands in [11:10] and the sixth in [1:0].
REQ-017 SHALL count nits 0..NITS-1; on the NITS-th color_valid it SHALL push the completed word into a 2-entry write FIFO and clear the nit count in the same cycle.
REQ-018 SHALL, when a word completes while the FIFO is full, drop that word and set overflow.
REQ-019 SHALL run FSM states IDLE, WRITE, READ, READ_DATA; every RAM output SHALL be registered.
REQ-020 From IDLE: FIFO non-empty only -> WRITE; cpu_req only -> READ; both pending -> the opposite of the last granted type (last_grant resets to READ, so the first tie goes to WRITE); neither -> stay in IDLE.
REQ-021 WRITE SHALL, for exactly one cycle, drive ram_we=1, ram_addr=write pointer and ram_din=FIFO head; it SHALL then pop the FIFO, increment the write pointer and load_count, and return to IDLE.
REQ-022 READ SHALL drive ram_addr=cpu_addr with ram_we=0 and pulse cpu_ack, then move to READ_DATA.
REQ-023 READ_DATA SHALL capture ram_dout into cpu_rdata, pulse cpu_rvalid the following cycle, and return to IDLE; cpu_req-to-cpu_rvalid latency is 3 cycles when uncontested.
REQ-024 After the write to address 2^ADDR_W-1, load_full SHALL set; completed words arriving after that point are dropped and set overflow; the write pointer SHALL NOT wrap.
REQ-025 load_start SHALL clear the nit count, partial word, FIFO, write pointer, load_count, load_full and overflow.
REQ-026 load_start SHALL NOT abort a READ or READ_DATA in progress; a WRITE in progress completes, but its pointer/count update is discarded.
REQ-027 load_start together with color_valid in the same cycle: load_start wins and the nit is discarded.
REQ-028 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, with no data loss.
REQ-029 cpu_req while a WRITE is in progress SHALL be held pending; it is served no later than after one further write.

Reset
REQ-030 Asserting reset SHALL immediately set the FSM to IDLE and set ram_we, cpu_ack, cpu_rvalid, load_full and overflow to 0; cpu_rdata, ram_addr, ram_din, load_count, the write pointer, the nit count and the FIFO all reset to 0; last_grant resets to READ.
REQ-031 Release of reset SHALL be synchronous to clk; the first arbitration occurs on the first rising edge after release.

Verification
REQ-032 load_start, then nits 3,0,1,2,3,1 -> one write: addr 0x00, din 0xC6D, ram_we high for 1 cycle; load_count=1.
REQ-033 RAM preloaded with 0xABC at 0x05; cpu_req, cpu_addr=0x05 -> cpu_ack in cycle 1, cpu_rdata=0xABC with cpu_rvalid in cycle 3.
REQ-034 FIFO holding 2 words while cpu_req is held -> grant order WRITE, READ, WRITE; no word is lost.
REQ-035 Stream 257 words -> addresses 0x00..0xFF written, load_full=1, overflow=1, load_count=256, no wrap to 0x00.
REQ-036 After 3 nits, pulse load_start with color_valid in the same cycle, then send 6 nits 1 -> word 0x555 written at addr 0x00.
REQ-037 Assert reset during READ_DATA -> cpu_rvalid stays 0, all outputs take their REQ-030 values, and a new cpu_req after release is served normally.
